// File: rtl/opora_load_ctrl_pkg.sv
// Shared constants, FSM encoding and error codes for the reference-coefficient loader.
package opora_load_ctrl_pkg;

  localparam int OPORA_N        = 4;
  localparam int OPORA_MULT_N   = 25;
  localparam int NUM_OPORA      = OPORA_N * OPORA_MULT_N;
  localparam int OPORA_HOLD_TMO = 1023;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } opora_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHKSUM   = 2'd1;
  localparam logic [1:0] ERR_HOLD_TMO = 2'd2;
  localparam logic [1:0] ERR_STRAY    = 2'd3;

endpackage

// File: rtl/opora_load_ctrl_addr_gen.sv
// Block addressing for coefficient writes: word-in-block counter, block pointer,
// and a registered one-hot write enable (one cycle after the accepted word).
module opora_addr_gen
  import opora_load_ctrl_pkg::*;
#(
  parameter int N      = OPORA_N,
  parameter int MULT_N = OPORA_MULT_N
) (
  input  logic         clke,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         adv_i,
  output logic [N-1:0] koef_en_o,
  output logic         last_o
);

  localparam int CW = (MULT_N > 1) ? $clog2(MULT_N) : 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  en_q, en_d;
  logic          blk_end;

  assign blk_end = (cnt_q == CW'(MULT_N - 1));
  assign last_o  = blk_end && (ptr_q == PW'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    en_d  = '0;
    if (clr_i) begin
      cnt_d = '0;
      ptr_d = '0;
    end else if (adv_i) begin
      en_d[ptr_q] = 1'b1;
      if (blk_end) begin
        cnt_d = '0;
        ptr_d = ptr_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clke) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ptr_q <= '0;
      en_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      en_q  <= en_d;
    end
  end

  assign koef_en_o = en_q;

endmodule

// File: rtl/opora_load_ctrl.sv
// Loads a reference frame of N*MULT_N coefficients into the convolution blocks while
// the datapath is frozen, then verifies a trailing 16-bit checksum word.
//   state | meaning
//   IDLE  | no frame since reset
//   HOLD  | hold_req raised, waiting for hold_ack (bounded by HOLD_TMO)
//   LOAD  | forwarding words to the block selected by the address generator
//   CHECK | next word is the checksum
//   DONE  | reference valid
//   ERR   | load_err holds the failure code until the next frame_start
module opora_load_ctrl
  import opora_load_ctrl_pkg::*;
#(
  parameter int N        = OPORA_N,
  parameter int MULT_N   = OPORA_MULT_N,
  parameter int HOLD_TMO = OPORA_HOLD_TMO
) (
  input  logic         clke,
  input  logic         rst_n,
  input  logic         frame_start,
  input  logic         opora_en,
  input  logic [15:0]  OPORA,
  input  logic         hold_ack,
  output logic         hold_req,
  output logic [N-1:0] koef_en,
  output logic [15:0]  KOEF_OUT,
  output logic         load_done,
  output logic [1:0]   load_err
);

  localparam int TW = (HOLD_TMO > 0) ? $clog2(HOLD_TMO + 1) : 1;

  opora_state_e  state_q, state_d;
  logic [1:0]    err_q, err_d;
  logic [15:0]   chk_q, chk_d;
  logic [15:0]   koef_q, koef_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          clr, adv, last_word;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    chk_d   = chk_q;
    koef_d  = koef_q;
    tmo_d   = tmo_q;
    clr     = 1'b0;
    adv     = 1'b0;
    // frame_start overrides everything, including a coincident word
    if (frame_start) begin
      state_d = ST_HOLD;
      err_d   = ERR_NONE;
      chk_d   = '0;
      tmo_d   = TW'(HOLD_TMO);
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_ack) begin
            state_d = ST_LOAD;
          end else if (tmo_q == '0) begin
            state_d = ST_ERR;
            err_d   = ERR_HOLD_TMO;
          end else begin
            tmo_d = tmo_q - 1'b1;
          end
        end
        ST_LOAD: begin
          if (!hold_ack) begin
            state_d = ST_ERR;
            err_d   = ERR_HOLD_TMO;
          end else if (opora_en) begin
            adv    = 1'b1;
            koef_d = OPORA;
            chk_d  = chk_q + OPORA;
            if (last_word) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!hold_ack) begin
            state_d = ST_ERR;
            err_d   = ERR_HOLD_TMO;
          end else if (opora_en) begin
            if (OPORA == chk_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ERR;
              err_d   = ERR_CHKSUM;
            end
          end
        end
        ST_DONE: begin
          if (opora_en) begin
            state_d = ST_ERR;
            err_d   = ERR_STRAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clke) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      chk_q   <= '0;
      koef_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      koef_q  <= koef_d;
      tmo_q   <= tmo_d;
    end
  end

  opora_addr_gen #(
    .N      (N),
    .MULT_N (MULT_N)
  ) u_addr_gen (
    .clke      (clke),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .adv_i     (adv),
    .koef_en_o (koef_en),
    .last_o    (last_word)
  );

  assign hold_req  = (state_q == ST_HOLD) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign load_done = (state_q == ST_DONE);
  assign load_err  = err_q;
  assign KOEF_OUT  = koef_q;

endmodule

// File: tb/tb_opora_load_ctrl.sv
// Directed bench for opora_load_ctrl: a short vector table plus multi-cycle frame sequences.
module tb_opora_load_ctrl;

  localparam int N        = 4;
  localparam int MULT_N   = 25;
  localparam int HOLD_TMO = 1023;

  logic        clke = 1'b0;
  logic        rst_n, frame_start, opora_en, hold_ack;
  logic [15:0] OPORA;
  logic        hold_req, load_done;
  logic [N-1:0] koef_en;
  logic [15:0] KOEF_OUT;
  logic [1:0]  load_err;

  int checks   = 0;
  int failures = 0;

  always #5 clke = ~clke;

  opora_load_ctrl #(.N(N), .MULT_N(MULT_N), .HOLD_TMO(HOLD_TMO)) dut (
    .clke        (clke),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .opora_en    (opora_en),
    .OPORA       (OPORA),
    .hold_ack    (hold_ack),
    .hold_req    (hold_req),
    .koef_en     (koef_en),
    .KOEF_OUT    (KOEF_OUT),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  typedef struct {
    logic        fs;
    logic        en;
    logic [15:0] op;
    logic        ack;
    logic        hold;
    logic [3:0]  ken;
    logic [15:0] koef;
    logic        done;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clke);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    opora_en    = 1'b0;
    hold_ack    = 1'b1;
    step();
    frame_start = 1'b0;
    check("start_hold_req", 32'(hold_req), 32'd1);
    step();
  endtask

  // words 1..n; word w belongs to block (w-1)/MULT_N
  task automatic load_words(input int n, input string tag);
    for (int w = 1; w <= n; w++) begin
      opora_en = 1'b1;
      OPORA    = 16'(w);
      step();
      check({tag, "_koef_en"}, 32'(koef_en), 32'(4'b0001 << ((w - 1) / MULT_N)));
      check({tag, "_koef_out"}, 32'(KOEF_OUT), 32'(w));
    end
    opora_en = 1'b0;
  endtask

  task automatic send_checksum(input logic [15:0] val, input string tag);
    opora_en = 1'b1;
    OPORA    = val;
    step();
    opora_en = 1'b0;
    check({tag, "_no_pulse"}, 32'(koef_en), 32'd0);
  endtask

  task automatic check_outputs(input string tag, input logic hold, input logic done,
                               input logic [1:0] err);
    check({tag, "_hold_req"}, 32'(hold_req), 32'(hold));
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_err"}, 32'(load_err), 32'(err));
  endtask

  initial begin
    //           fs    en    op        ack   hold  ken      koef      done  err
    vecs[0]  = '{1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b0000, 16'h0000, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0007, 1'b0, 1'b1, 4'b0000, 16'h0000, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 16'h0000, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 4'b0001, 16'h1111, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 16'h1111, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, 16'h2222, 1'b1, 1'b1, 4'b0001, 16'h2222, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 1'b1, 16'h3333, 1'b1, 1'b1, 4'b0000, 16'h2222, 1'b0, 2'd0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b0000, 16'h2222, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 16'h2222, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 4'b0001, 16'h4444, 1'b0, 2'd0};
    vecs[11] = '{1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 4'b0000, 16'h4444, 1'b0, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 16'h6666, 1'b0, 1'b0, 4'b0000, 16'h4444, 1'b0, 2'd2};

    rst_n       = 1'b0;
    frame_start = 1'b0;
    opora_en    = 1'b0;
    hold_ack    = 1'b0;
    OPORA       = 16'h0;
    step();
    step();
    check_outputs("reset", 1'b0, 1'b0, 2'd0);
    check("reset_koef_en", 32'(koef_en), 32'd0);
    check("reset_koef_out", 32'(KOEF_OUT), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      frame_start = vecs[i].fs;
      opora_en    = vecs[i].en;
      OPORA       = vecs[i].op;
      hold_ack    = vecs[i].ack;
      step();
      check($sformatf("vec%0d_hold_req", i), 32'(hold_req), 32'(vecs[i].hold));
      check($sformatf("vec%0d_koef_en", i), 32'(koef_en), 32'(vecs[i].ken));
      check($sformatf("vec%0d_koef_out", i), 32'(KOEF_OUT), 32'(vecs[i].koef));
      check($sformatf("vec%0d_load_done", i), 32'(load_done), 32'(vecs[i].done));
      check($sformatf("vec%0d_load_err", i), 32'(load_err), 32'(vecs[i].err));
    end
    frame_start = 1'b0;
    opora_en    = 1'b0;

    // valid frame, checksum 5050 = 0x13BA
    start_frame();
    load_words(100, "good");
    send_checksum(16'h13BA, "good_chk");
    check_outputs("good_done", 1'b0, 1'b1, 2'd0);

    // bad checksum
    start_frame();
    load_words(100, "bad");
    send_checksum(16'h13BB, "bad_chk");
    check_outputs("bad_err", 1'b0, 1'b0, 2'd1);

    // hold timeout: load_err=2 exactly HOLD_TMO+1 cycles after entering HOLD
    begin
      int pulses = 0;
      hold_ack    = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check_outputs("tmo_enter", 1'b1, 1'b0, 2'd0);
      for (int c = 1; c <= HOLD_TMO; c++) begin
        opora_en = c[0];
        OPORA    = 16'(c);
        step();
        if (koef_en != '0) pulses++;
      end
      opora_en = 1'b0;
      check_outputs("tmo_last_wait", 1'b1, 1'b0, 2'd0);
      step();
      check_outputs("tmo_fire", 1'b0, 1'b0, 2'd2);
      check("tmo_no_koef_en", 32'(pulses), 32'd0);
    end

    // abort after word 40, then a full valid frame
    start_frame();
    load_words(40, "abort_part");
    start_frame();
    load_words(100, "abort_full");
    send_checksum(16'h13BA, "abort_chk");
    check_outputs("abort_done", 1'b0, 1'b1, 2'd0);

    // reset mid-load after word 60
    start_frame();
    load_words(60, "rst_part");
    rst_n = 1'b0;
    step();
    check_outputs("midrst", 1'b0, 1'b0, 2'd0);
    check("midrst_koef_en", 32'(koef_en), 32'd0);
    check("midrst_koef_out", 32'(KOEF_OUT), 32'd0);
    rst_n    = 1'b1;
    hold_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      opora_en = 1'b1;
      OPORA    = 16'(16'h0100 + i);
      step();
      check($sformatf("postrst_word%0d_koef_en", i), 32'(koef_en), 32'd0);
      check($sformatf("postrst_word%0d_hold", i), 32'(hold_req), 32'd0);
    end
    opora_en = 1'b0;

    // stray word after DONE
    start_frame();
    load_words(100, "stray");
    send_checksum(16'h13BA, "stray_chk");
    check_outputs("stray_done", 1'b0, 1'b1, 2'd0);
    opora_en = 1'b1;
    OPORA    = 16'h0000;
    step();
    opora_en = 1'b0;
    check_outputs("stray_err", 1'b0, 1'b0, 2'd3);
    check("stray_koef_en", 32'(koef_en), 32'd0);

    // frame_start coincident with opora_en after DONE
    start_frame();
    load_words(100, "coin");
    send_checksum(16'h13BA, "coin_chk");
    check_outputs("coin_done", 1'b0, 1'b1, 2'd0);
    frame_start = 1'b1;
    opora_en    = 1'b1;
    OPORA       = 16'hBEEF;
    hold_ack    = 1'b1;
    step();
    frame_start = 1'b0;
    opora_en    = 1'b0;
    check_outputs("coin_hold", 1'b1, 1'b0, 2'd0);
    check("coin_koef_en", 32'(koef_en), 32'd0);
    check("coin_koef_out", 32'(KOEF_OUT), 32'd100);
    step();
    opora_en = 1'b1;
    OPORA    = 16'h0ABC;
    step();
    opora_en = 1'b0;
    check("coin_first_koef_en", 32'(koef_en), 32'd1);
    check("coin_first_koef_out", 32'(KOEF_OUT), 32'h0ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/opora_load_ctrl.md
OPORA_LOAD_CTRL -- requirements
Module: opora_load_ctrl

Interface
REQ-001 Parameter N, default 4, number of convolution blocks fed with reference coefficients.
REQ-002 Parameter MULT_N, default 25, coefficients per block; NUM_OPORA = N*MULT_N (100).
REQ-003 Parameter HOLD_TMO, default 1023, clke cycles to wait for hold_ack.
REQ-004 clke  in  1  single clock, ethernet domain; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 frame_start  in  1  one-cycle pulse, a new reference frame follows.
REQ-007 opora_en  in  1  word strobe from PC.
REQ-008 OPORA  in  16  reference word, two's complement.
REQ-009 hold_ack  in  1  convolution datapath is frozen (pre-synchronised to clke).
REQ-010 hold_req  out  1  request to freeze the convolution datapath.
REQ-011 koef_en  out  N  one-hot write enable, bit a selects block a.
REQ-012 KOEF_OUT  out  16  registered coefficient word.
REQ-013 load_done  out  1  reference valid, level.
REQ-014 load_err  out  2  error code: 0 none, 1 checksum, 2 hold timeout, 3 stray word.

Function
REQ-015 FSM states IDLE, HOLD, LOAD, CHECK, DONE, ERR.
REQ-016 frame_start in IDLE, DONE or ERR -> HOLD; clear word count, checksum, load_done, load_err; assert hold_req.
REQ-017 HOLD: hold_ack=1 -> LOAD; timeout counter reaching HOLD_TMO without hold_ack -> ERR, code 2.
REQ-018 LOAD: each opora_en registers OPORA into KOEF_OUT and pulses koef_en[word_cnt/MULT_N] for exactly one cycle, 1-cycle latency.
REQ-019 LOAD: word_cnt increments per opora_en; checksum += OPORA modulo 2^16.
REQ-020 LOAD: after word NUM_OPORA-1 is accepted -> CHECK; no koef_en pulse for later words.
REQ-021 CHECK: next opora_en word compared with checksum; equal -> DONE, different -> ERR code 1.
REQ-022 DONE: load_done=1, hold_req=0.
REQ-023 ERR: load_done=0, hold_req=0, load_err holds code until next frame_start.
REQ-024 opora_en in IDLE, DONE or HOLD ignored (no koef_en); in DONE it moves to ERR with code 3.
REQ-025 frame_start during HOLD, LOAD or CHECK restarts at HOLD (abort); hold_req stays asserted.
REQ-026 frame_start and opora_en in the same cycle: frame_start wins; word discarded.
REQ-027 hold_ack falling during LOAD/CHECK -> ERR, code 2.
REQ-028 koef_en is never more than one-hot; never asserted outside LOAD.
REQ-029 Block index = word_cnt/MULT_N via a per-block counter (0..MULT_N-1) plus block pointer; no divider.

Reset
REQ-030 rst_n=0 at a clke edge: state IDLE, hold_req=0, koef_en=0, KOEF_OUT=0, load_done=0, load_err=0, counters and checksum 0.
REQ-031 Reset mid-LOAD aborts without further koef_en pulses; next frame needs a fresh frame_start.

Structure
REQ-032 A shared package holds N, MULT_N, NUM_OPORA, FSM state encoding and error codes, for reuse by the convolution top.
REQ-033 One sub-module, opora_addr_gen: per-block word counter, block pointer and one-hot koef_en decode.

Verification
REQ-034 Frame of 100 words 1..100, checksum 5050 mod 65536 = 0x13BA -> koef_en[0] for words 1-25, [1] for 26-50, [2] for 51-75, [3] for 76-100; load_done=1, load_err=0.
REQ-035 Same frame with checksum 0x13BB -> ERR, load_err=1, load_done=0, hold_req=0.
REQ-036 hold_ack held 0 -> load_err=2 exactly HOLD_TMO+1 cycles after entering HOLD; no koef_en.
REQ-037 frame_start after word 40, then full valid frame -> second frame's word 1 on koef_en[0]; DONE.
REQ-038 rst_n=0 after word 60 -> all outputs 0 next cycle; opora_en words ignored until frame_start.
REQ-039 After DONE, one opora_en -> ERR, load_err=3; frame_start coincident with opora_en -> HOLD, word discarded.
